// File: rtl/usm_page_burst_splitter_if.sv
// Avalon-MM style command/data bundle used on both sides of the page burst splitter.
// A command or write beat transfers on a cycle where read/write is high and waitrequest
// is low; the master holds its outputs stable while waitrequest is high, and
// readdatavalid has no backpressure.
interface usm_page_burst_splitter_if #(
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0]      address;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic                       read;
  logic                       write;
  logic [DATA_WIDTH-1:0]      writedata;
  logic [DATA_WIDTH/8-1:0]    byteenable;
  logic                       waitrequest;
  logic [DATA_WIDTH-1:0]      readdata;
  logic                       readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/usm_page_burst_splitter.sv
// Splits kernel USM read/write bursts that cross a translation page into page-contained
// sub-bursts; read and write data pass straight through, only commands are re-sequenced.
module usm_page_burst_splitter #(
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int PAGE_BYTES      = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  usm_page_burst_splitter_if.slave  src,
  usm_page_burst_splitter_if.master sink,
  output logic [15:0]               split_events,
  output logic [1:0]                dbg_state_o
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int BEAT_BITS      = $clog2(BYTES_PER_BEAT);
  localparam int PAGE_BITS      = $clog2(PAGE_BYTES);
  localparam logic [PAGE_BITS:0]         PAGE_SIZE = (PAGE_BITS + 1)'(PAGE_BYTES);
  localparam logic [BURST_CNT_WIDTH-1:0] ONE       = BURST_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      cur_addr_q, cur_addr_d;
  logic [BURST_CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [BURST_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]                split_q, split_d;

  logic [BURST_CNT_WIDTH-1:0] src_len;
  logic [BURST_CNT_WIDTH-1:0] sub_base;
  logic [BURST_CNT_WIDTH-1:0] sub_len;
  logic [PAGE_BITS:0]         page_off;
  logic [PAGE_BITS:0]         bytes_to_end;
  logic [31:0]                beats_to_end;
  logic [ADDR_WIDTH-1:0]      sub_bytes;

  assign src_len = (src.burstcount == '0) ? ONE : src.burstcount;

  // In WR, remaining counts down per beat; adding back the beats already sent gives the
  // remaining count at the start of this sub-burst, which keeps sub_len stable within it.
  assign sub_base     = (state_q == ST_WR) ? remaining_q + beat_cnt_q : remaining_q;
  assign page_off     = {1'b0, cur_addr_q[PAGE_BITS-1:0]};
  assign bytes_to_end = PAGE_SIZE - page_off;
  assign beats_to_end = 32'(bytes_to_end >> BEAT_BITS);
  assign sub_len      = (32'(sub_base) <= beats_to_end) ? sub_base
                                                         : beats_to_end[BURST_CNT_WIDTH-1:0];
  assign sub_bytes    = ADDR_WIDTH'(sub_len) << BEAT_BITS;

  assign src.readdata      = sink.readdata;
  assign src.readdatavalid = sink.readdatavalid;
  assign sink.writedata    = src.writedata;
  assign sink.byteenable   = src.byteenable;
  assign split_events      = split_q;
  assign dbg_state_o       = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      split_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      split_q     <= split_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cur_addr_d       = cur_addr_q;
    remaining_d      = remaining_q;
    beat_cnt_d       = beat_cnt_q;
    split_d          = split_q;
    src.waitrequest  = 1'b1;
    sink.read        = 1'b0;
    sink.write       = 1'b0;
    sink.address     = '0;
    sink.burstcount  = '0;

    case (state_q)
      ST_IDLE: begin
        beat_cnt_d = '0;
        if (src.read) begin
          cur_addr_d  = src.address;
          remaining_d = src_len;
          state_d     = ST_RD;
        end else if (src.write) begin
          cur_addr_d  = src.address;
          remaining_d = src_len;
          state_d     = ST_WR;
        end
      end

      ST_RD: begin
        sink.read       = 1'b1;
        sink.address    = cur_addr_q;
        sink.burstcount = sub_len;
        if (!sink.waitrequest) begin
          cur_addr_d  = cur_addr_q + sub_bytes;
          remaining_d = remaining_q - sub_len;
          if (remaining_q == sub_len) begin
            src.waitrequest = 1'b0;
            state_d         = ST_IDLE;
          end else begin
            split_d = split_q + 16'd1;
          end
        end
      end

      ST_WR: begin
        sink.write      = src.write;
        sink.address    = cur_addr_q;
        sink.burstcount = sub_len;
        src.waitrequest = sink.waitrequest;
        if (src.write && !sink.waitrequest) begin
          remaining_d = remaining_q - ONE;
          if (beat_cnt_q + ONE == sub_len) begin
            beat_cnt_d = '0;
            cur_addr_d = cur_addr_q + sub_bytes;
            if (remaining_q == ONE) begin
              state_d = ST_IDLE;
            end else begin
              split_d = split_q + 16'd1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + ONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usm_page_burst_splitter.sv
// Directed bench for usm_page_burst_splitter: page-crossing reads/writes, stalls, bubbles,
// reset abort, burstcount 0, and split_events wrap on a small-page instance.
module tb_usm_page_burst_splitter;

  localparam int AW  = 48;
  localparam int DW  = 512;
  localparam int BW  = 7;
  localparam int DW2 = 64;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] split_events, split2;
  logic [1:0]  dbg_state, dbg_state2;
  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0]   wd [8];
  logic [DW/8-1:0] be_all;

  usm_page_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) src_if ();
  usm_page_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) sink_if ();
  usm_page_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW2), .BURST_CNT_WIDTH(BW)) src2_if ();
  usm_page_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW2), .BURST_CNT_WIDTH(BW)) sink2_if ();

  usm_page_burst_splitter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .PAGE_BYTES(4096)
  ) dut (
    .clk(clk), .reset(reset), .src(src_if), .sink(sink_if),
    .split_events(split_events), .dbg_state_o(dbg_state)
  );

  // One beat per page: every beat after the first of a burst is an extra sub-burst.
  usm_page_burst_splitter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW2), .BURST_CNT_WIDTH(BW), .PAGE_BYTES(8)
  ) dut_small (
    .clk(clk), .reset(reset), .src(src2_if), .sink(sink2_if),
    .split_events(split2), .dbg_state_o(dbg_state2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                        input logic last);
    #1;
    check({tag, "_read"}, sink_if.read, 1'b1);
    check({tag, "_addr"}, sink_if.address, a);
    check({tag, "_bc"}, sink_if.burstcount, bc);
    check({tag, "_srcwait"}, src_if.waitrequest, !last);
    step();
  endtask

  task automatic chk_wr(input string tag, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                        input logic [DW-1:0] d, input logic [DW/8-1:0] be, input logic exp_wait);
    src_if.write      = 1'b1;
    src_if.writedata  = d;
    src_if.byteenable = be;
    #1;
    check({tag, "_write"}, sink_if.write, 1'b1);
    check({tag, "_addr"}, sink_if.address, a);
    check({tag, "_bc"}, sink_if.burstcount, bc);
    check({tag, "_data"}, sink_if.writedata, d);
    check({tag, "_be"}, sink_if.byteenable, be);
    check({tag, "_srcwait"}, src_if.waitrequest, exp_wait);
    step();
  endtask

  task automatic stress_rd(input logic [BW-1:0] bc);
    logic done;
    done = 1'b0;
    src2_if.read       = 1'b1;
    src2_if.address    = '0;
    src2_if.burstcount = bc;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (!src2_if.waitrequest) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("t6_burst_done", done, 1'b1);
    step();
    src2_if.read = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) wd[i] = {16{32'hA500_0000 + 32'(i)}};
    be_all = '1;
    reset = 1'b1;
    src_if.address = '0;  src_if.burstcount = '0; src_if.read = 1'b0; src_if.write = 1'b0;
    src_if.writedata = '0; src_if.byteenable = '0;
    sink_if.waitrequest = 1'b0; sink_if.readdata = '0; sink_if.readdatavalid = 1'b0;
    src2_if.address = '0; src2_if.burstcount = '0; src2_if.read = 1'b0; src2_if.write = 1'b0;
    src2_if.writedata = '0; src2_if.byteenable = '0;
    sink2_if.waitrequest = 1'b0; sink2_if.readdata = '0; sink2_if.readdatavalid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_srcwait", src_if.waitrequest, 1'b1);
    check("rst_read", sink_if.read, 1'b0);
    check("rst_write", sink_if.write, 1'b0);
    check("rst_bc", sink_if.burstcount, 0);
    check("rst_addr", sink_if.address, 0);
    check("rst_split", split_events, 0);
    step();

    // Read crossing one page: (0x0FC0,1) then (0x1000,3), one sink stall first.
    src_if.read = 1'b1; src_if.address = 48'h0FC0; src_if.burstcount = 7'd4;
    sink_if.waitrequest = 1'b1;
    #1;
    check("t1_idle_srcwait", src_if.waitrequest, 1'b1);
    check("t1_idle_read", sink_if.read, 1'b0);
    step();
    #1;
    check("t1_stall_read", sink_if.read, 1'b1);
    check("t1_stall_addr", sink_if.address, 48'h0FC0);
    check("t1_stall_srcwait", src_if.waitrequest, 1'b1);
    step();
    sink_if.waitrequest = 1'b0;
    chk_rd("t1_sub0", 48'h0FC0, 7'd1, 1'b0);
    chk_rd("t1_sub1", 48'h1000, 7'd3, 1'b1);
    src_if.read = 1'b0;
    #1;
    check("t1_end_state", dbg_state, S_IDLE);
    check("t1_end_read", sink_if.read, 1'b0);
    check("t1_split", split_events, 16'd1);
    for (int i = 0; i < 4; i++) begin
      sink_if.readdata = {16{32'hC0DE_0000 + 32'(i)}};
      sink_if.readdatavalid = 1'b1;
      #1;
      check($sformatf("t1_rdata%0d", i), src_if.readdata, {16{32'hC0DE_0000 + 32'(i)}});
      check($sformatf("t1_rvalid%0d", i), src_if.readdatavalid, 1'b1);
      step();
    end
    sink_if.readdatavalid = 1'b0;
    #1;
    check("t1_rvalid_low", src_if.readdatavalid, 1'b0);
    step();

    // Write 8 beats at 0x1F80: two beats in one page, six in the next.
    src_if.write = 1'b1; src_if.address = 48'h1F80; src_if.burstcount = 7'd8;
    src_if.writedata = wd[0]; src_if.byteenable = be_all;
    #1;
    check("t2_idle_srcwait", src_if.waitrequest, 1'b1);
    check("t2_idle_write", sink_if.write, 1'b0);
    step();
    for (int i = 0; i < 8; i++)
      chk_wr($sformatf("t2_b%0d", i), (i < 2) ? 48'h1F80 : 48'h2000, (i < 2) ? 7'd2 : 7'd6,
             wd[i], ~(64'd1 << i), 1'b0);
    src_if.write = 1'b0;
    #1;
    check("t2_end_state", dbg_state, S_IDLE);
    check("t2_split", split_events, 16'd2);
    step();

    // Full page-aligned 64-beat read stays one sub-burst.
    src_if.read = 1'b1; src_if.address = 48'h3000; src_if.burstcount = 7'd64;
    #1;
    check("t3_idle_read", sink_if.read, 1'b0);
    step();
    chk_rd("t3_single", 48'h3000, 7'd64, 1'b1);
    src_if.read = 1'b0;
    #1;
    check("t3_end_state", dbg_state, S_IDLE);
    check("t3_split", split_events, 16'd2);
    step();

    // burstcount 0 behaves as a single beat.
    src_if.read = 1'b1; src_if.address = 48'h0040; src_if.burstcount = 7'd0;
    step();
    chk_rd("t3b_zero", 48'h0040, 7'd1, 1'b1);
    src_if.read = 1'b0;
    #1;
    check("t3b_end_state", dbg_state, S_IDLE);
    check("t3b_split", split_events, 16'd2);
    step();

    // Write 3 beats at 0x0FC0 with a 3-cycle sink stall on beat 2 and a kernel bubble.
    src_if.write = 1'b1; src_if.address = 48'h0FC0; src_if.burstcount = 7'd3;
    src_if.writedata = wd[0];
    step();
    chk_wr("t4_b0", 48'h0FC0, 7'd1, wd[0], be_all, 1'b0);
    sink_if.waitrequest = 1'b1;
    for (int k = 0; k < 3; k++)
      chk_wr($sformatf("t4_b1_stall%0d", k), 48'h1000, 7'd2, wd[1], be_all, 1'b1);
    sink_if.waitrequest = 1'b0;
    chk_wr("t4_b1", 48'h1000, 7'd2, wd[1], be_all, 1'b0);
    src_if.write = 1'b0;
    #1;
    check("t4_bubble_write", sink_if.write, 1'b0);
    check("t4_bubble_addr", sink_if.address, 48'h1000);
    check("t4_bubble_bc", sink_if.burstcount, 7'd2);
    check("t4_bubble_state", dbg_state, S_WR);
    step();
    chk_wr("t4_b2", 48'h1000, 7'd2, wd[2], be_all, 1'b0);
    src_if.write = 1'b0;
    #1;
    check("t4_end_state", dbg_state, S_IDLE);
    check("t4_split", split_events, 16'd3);
    step();

    // Reset during the second read sub-burst aborts to IDLE; returning data still flows.
    src_if.read = 1'b1; src_if.address = 48'h0FC0; src_if.burstcount = 7'd4;
    step();
    chk_rd("t5_sub0", 48'h0FC0, 7'd1, 1'b0);
    reset = 1'b1;
    src_if.read = 1'b0;
    #1;
    check("t5_pre_state", dbg_state, S_RD);
    step();
    reset = 1'b0;
    sink_if.readdata = {16{32'h5EED_F00D}};
    sink_if.readdatavalid = 1'b1;
    #1;
    check("t5_state", dbg_state, S_IDLE);
    check("t5_read", sink_if.read, 1'b0);
    check("t5_srcwait", src_if.waitrequest, 1'b1);
    check("t5_split", split_events, 16'd0);
    check("t5_rvalid", src_if.readdatavalid, 1'b1);
    check("t5_rdata", src_if.readdata, {16{32'h5EED_F00D}});
    step();
    sink_if.readdatavalid = 1'b0;
    src_if.read = 1'b1; src_if.address = 48'h0; src_if.burstcount = 7'd1;
    step();
    chk_rd("t5_after", 48'h0, 7'd1, 1'b1);
    src_if.read = 1'b0;
    #1;
    check("t5_after_state", dbg_state, S_IDLE);
    check("t5_after_split", split_events, 16'd0);
    step();

    // split_events wrap: 1040 x 63 = 0xFFF0, +15 = 0xFFFF, +1 wraps to 0.
    for (int b = 0; b < 1040; b++) stress_rd(7'd64);
    #1;
    check("t6_fff0", split2, 16'hFFF0);
    stress_rd(7'd16);
    #1;
    check("t6_ffff", split2, 16'hFFFF);
    stress_rd(7'd2);
    #1;
    check("t6_wrap", split2, 16'h0000);
    check("t6_state", dbg_state2, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
